// File: rtl/uart_rx.sv
// uart_rx: 8-bit MSB-first serial receiver with a two-flop input synchronizer.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN; by default
// the frame is start + 8 data + stop and PARITY_ERR is tied low.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_EN,
  input  logic       RX_IN,
  output logic [7:0] DATA_OUT,
  output logic       VALID,
  output logic       BUSY,
  output logic       FRAME_ERR,
  output logic       PARITY_ERR
);

  localparam int CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int HALF = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START_BIT  = 3'd1,
    DATA_BITS  = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY_BIT = 3'd3,
`endif
    STOP_BIT   = 3'd4
  } state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        rx_meta;
  logic        rxs;

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic par_err_q;
  assign PARITY_ERR = par_err_q;
`else
  assign PARITY_ERR = 1'b0;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= RX_IN;
      rxs     <= rx_meta;
    end
  end

  // Receive FSM: mid-bit sampling, counter cleared at every sample point.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      DATA_OUT  <= '0;
      VALID     <= 1'b0;
      BUSY      <= 1'b0;
      FRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad   <= 1'b0;
      par_err_q <= 1'b0;
`endif
    end else begin
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (RX_EN && !rxs) begin
            state   <= START_BIT;
            bit_cnt <= '0;
            BUSY    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
          end
        end
        START_BIT: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rxs) begin
              // Line went back high before mid-start: glitch, not a frame.
              state <= IDLE;
              BUSY  <= 1'b0;
            end else begin
              state <= DATA_BITS;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA_BITS: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {shreg[6:0], rxs};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY_BIT;
`else
              state <= STOP_BIT;
`endif
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY_BIT: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            par_bad <= (^shreg) != rxs;
            state   <= STOP_BIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        STOP_BIT: begin
          if (cnt == BIT_LAST) begin
            // Back to IDLE right away so a start half a bit later is seen.
            cnt   <= '0;
            state <= IDLE;
            BUSY  <= 1'b0;
            if (!rxs) begin
              FRAME_ERR <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            else if (par_bad) begin
              par_err_q <= 1'b1;
            end
`endif
            else begin
              VALID    <= 1'b1;
              DATA_OUT <= shreg;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames plus hand-written corner sequences; a
// scoreboard queue holds expected pulses, popped by a negedge monitor.
module tb_uart_rx;

  localparam int CPB = 434;
`ifdef UART_RX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_VAL  = 2'd1;
  localparam logic [1:0] K_FERR = 2'd2;
  localparam logic [1:0] K_PERR = 2'd3;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_EN = 1'b0;
  logic       RX_IN = 1'b1;
  logic [7:0] DATA_OUT;
  logic       VALID, BUSY, FRAME_ERR, PARITY_ERR;

  always #5 CLK = ~CLK;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .RST(RST), .RX_EN(RX_EN), .RX_IN(RX_IN),
    .DATA_OUT(DATA_OUT), .VALID(VALID), .BUSY(BUSY),
    .FRAME_ERR(FRAME_ERR), .PARITY_ERR(PARITY_ERR)
  );

  typedef struct {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    bit         en;
    logic [1:0] kind;
    logic [7:0] dout;
  } vec_t;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc = 0;
  exp_t sbq[$];
  int   vcyc[$];
  bit   busy_next = 1'b0;
  exp_t mon_e;
  logic [1:0] mon_k;

  always @(posedge CLK) cyc++;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] d);
    exp_t e;
    e.kind = k;
    e.data = d;
    sbq.push_back(e);
  endtask

  // Drive one frame MSB first; optionally drop RX_EN once the start is seen.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_ok,
                            input bit drop_en);
    RX_IN = 1'b0;
    repeat (CPB) @(negedge CLK);
    if (drop_en) RX_EN = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      RX_IN = d[i];
      repeat (CPB) @(negedge CLK);
    end
`ifdef UART_RX_PARITY_EN
    RX_IN = (^d) ^ ~par_ok;
    repeat (CPB) @(negedge CLK);
`else
    if (par_ok) RX_IN = 1'b1;
`endif
    RX_IN = stop;
    repeat (CPB) @(negedge CLK);
    RX_IN = 1'b1;
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge CLK) begin
    if (busy_next) begin
      chk("busy_after_valid", 32'(BUSY), 32'd0);
      busy_next = 1'b0;
    end
    if (!RST && (VALID || FRAME_ERR || PARITY_ERR)) begin
      chk("pulse_exclusive", 32'($countones({VALID, FRAME_ERR, PARITY_ERR})), 32'd1);
      mon_k = VALID ? K_VAL : (FRAME_ERR ? K_FERR : K_PERR);
      if (sbq.size() == 0) begin
        chk("unexpected_pulse", 32'(mon_k), 32'(K_NONE));
      end else begin
        mon_e = sbq.pop_front();
        chk("pulse_kind", 32'(mon_k), 32'(mon_e.kind));
        if (VALID) begin
          chk("valid_data", 32'(DATA_OUT), 32'(mon_e.data));
          vcyc.push_back(cyc);
          busy_next = 1'b1;
        end
      end
    end
  end

  vec_t vt[4];

  initial begin
    vt[0] = '{d: 8'h5A, en: 1'b1, kind: K_VAL,  dout: 8'h5A};
    vt[1] = '{d: 8'hC3, en: 1'b0, kind: K_NONE, dout: 8'h5A};
    vt[2] = '{d: 8'h01, en: 1'b1, kind: K_VAL,  dout: 8'h01};
    vt[3] = '{d: 8'h80, en: 1'b1, kind: K_VAL,  dout: 8'h80};

    // Reset state, including reset overriding an active start condition.
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RX_EN = 1'b1;
    RX_IN = 1'b0;
    repeat (4) @(negedge CLK);
    chk("rst_data_out", 32'(DATA_OUT), 32'h00);
    chk("rst_valid", 32'(VALID), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_frame_err", 32'(FRAME_ERR), 32'd0);
    chk("rst_parity_err", 32'(PARITY_ERR), 32'd0);
    RX_IN = 1'b1;
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    chk("idle_busy", 32'(BUSY), 32'd0);

    // First frame 0xA5.
    push(K_VAL, 8'hA5);
    fork
      send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
      begin
        repeat (CPB) @(negedge CLK);
        chk("busy_mid_frame", 32'(BUSY), 32'd1);
      end
    join
    repeat (2 * CPB) @(negedge CLK);
    chk("a5_data_out", 32'(DATA_OUT), 32'hA5);
    chk("a5_sb_empty", 32'(sbq.size()), 32'd0);

    // False start: 100 low cycles, then high.
    RX_IN = 1'b0;
    repeat (50) @(negedge CLK);
    chk("false_start_busy", 32'(BUSY), 32'd1);
    repeat (50) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (CPB) @(negedge CLK);
    chk("false_start_clear", 32'(BUSY), 32'd0);
    chk("false_start_dout", 32'(DATA_OUT), 32'hA5);

    // Framing error on 0x3C; RX_EN dropped mid-frame so the low stop
    // bit is not taken as a new start once the FSM is idle again.
    push(K_FERR, 8'h00);
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    repeat (CPB) @(negedge CLK);
    RX_EN = 1'b1;
    repeat (CPB) @(negedge CLK);
    chk("ferr_dout_kept", 32'(DATA_OUT), 32'hA5);
    chk("ferr_sb_empty", 32'(sbq.size()), 32'd0);

    // Back-to-back frames, no idle gap.
    vcyc.delete();
    push(K_VAL, 8'h00);
    push(K_VAL, 8'hFF);
    send_frame(8'h00, 1'b1, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    repeat (2 * CPB) @(negedge CLK);
    chk("b2b_count", 32'(vcyc.size()), 32'd2);
    if (vcyc.size() == 2) chk("b2b_spacing", 32'(vcyc[1] - vcyc[0]), 32'(FB * CPB));
    chk("b2b_dout", 32'(DATA_OUT), 32'hFF);

    // Reset pulse during data bit 4 of 0x81: partial byte discarded.
    fork
      send_frame(8'h81, 1'b1, 1'b1, 1'b0);
      begin
        repeat (5 * CPB + CPB / 2) @(negedge CLK);
        chk("busy_before_rst", 32'(BUSY), 32'd1);
        RST = 1'b1;
        RX_EN = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_mid_idle", 32'(BUSY), 32'd0);
        chk("rst_mid_dout", 32'(DATA_OUT), 32'h00);
      end
    join
    repeat (CPB) @(negedge CLK);
    RX_EN = 1'b1;
    push(K_VAL, 8'h42);
    send_frame(8'h42, 1'b1, 1'b1, 1'b0);
    repeat (2 * CPB) @(negedge CLK);
    chk("after_rst_dout", 32'(DATA_OUT), 32'h42);

    // Table of ordinary frames (one with RX_EN low, which must be ignored).
    for (int i = 0; i < 4; i++) begin
      RX_EN = vt[i].en;
      if (vt[i].kind != K_NONE) push(vt[i].kind, vt[i].d);
      send_frame(vt[i].d, 1'b1, 1'b1, 1'b0);
      repeat (2 * CPB) @(negedge CLK);
      chk($sformatf("vec%0d_dout", i), 32'(DATA_OUT), 32'(vt[i].dout));
      chk($sformatf("vec%0d_busy", i), 32'(BUSY), 32'd0);
    end
    RX_EN = 1'b1;

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has three ones, so the correct parity bit is 1.
    push(K_PERR, 8'h00);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    repeat (2 * CPB) @(negedge CLK);
    chk("perr_dout_kept", 32'(DATA_OUT), 32'h80);
    push(K_VAL, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    repeat (2 * CPB) @(negedge CLK);
    chk("par_ok_dout", 32'(DATA_OUT), 32'h07);
`endif

    chk("sb_empty_final", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: UART_RX

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning CLK cycles per serial bit period.
REQ-002 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port RX_EN  input  1  high enables start-bit detection.
REQ-005 SHALL have port RX_IN  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port DATA_OUT  output  8  last correctly received byte.
REQ-007 SHALL have port VALID  output  1  one-cycle pulse marking a new byte on DATA_OUT.
REQ-008 SHALL have port BUSY  output  1  high from start-bit detection until return to IDLE.
REQ-009 SHALL have port FRAME_ERR  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 SHALL have port PARITY_ERR  output  1  one-cycle pulse on parity mismatch; constant 0 without UART_RX_PARITY_EN.

Function
REQ-011 SHALL pass RX_IN through a two-flop synchronizer, both flops reset to 1; all sampling uses the second flop (RXS).
REQ-012 SHALL implement states IDLE, START_BIT, DATA_BITS, PARITY_BIT (macro only), STOP_BIT; unused encodings go to IDLE next cycle.
REQ-013 SHALL, in IDLE with RX_EN=1 and RXS=0, enter START_BIT, clear the bit counter, and set BUSY=1 on the next edge.
REQ-014 SHALL ignore RXS=0 in IDLE while RX_EN=0; RX_EN deassertion mid-frame does not abort the frame.
REQ-015 SHALL, in START_BIT, resample RXS after CLKS_PER_BIT/2 (integer division) cycles; RXS=1 is a false start: return to IDLE, BUSY=0, no pulse.
REQ-016 SHALL, in DATA_BITS, sample RXS every CLKS_PER_BIT cycles after the start midpoint, 8 samples total.
REQ-017 SHALL receive MSB first: each sample shifts into bit 0 of a shift register shifted left, so the first sample ends in bit 7.
REQ-018 SHALL sample the stop bit CLKS_PER_BIT cycles after the last data or parity sample.
REQ-019 SHALL, on stop sample 1 with no parity error, load DATA_OUT and pulse VALID high for exactly that cycle.
REQ-020 SHALL, on stop sample 0, pulse FRAME_ERR for one cycle; DATA_OUT is unchanged and VALID stays 0.
REQ-021 SHALL return to IDLE, BUSY=0, in the cycle after the stop sample, so a start bit arriving half a bit later is accepted.
REQ-022 SHALL size the cycle counter to $clog2(CLKS_PER_BIT) bits and clear it at every sample point; it never wraps mid-bit.
REQ-023 SHALL never assert VALID, FRAME_ERR and PARITY_ERR in the same cycle.

Reset
REQ-024 SHALL, while RST=1, force state IDLE, counters 0, shift register 0x00, DATA_OUT=0x00, VALID=0, BUSY=0, FRAME_ERR=0, PARITY_ERR=0, synchronizer flops=1.
REQ-025 SHALL, on RST mid-frame, discard the partial byte with no pulse and sit in IDLE from the first cycle after RST falls.
REQ-026 SHALL give RST priority over every other input.

Configuration
REQ-027 SHALL, with UART_RX_PARITY_EN defined, enter PARITY_BIT after the 8th data bit and sample one even-parity bit CLKS_PER_BIT cycles later.
REQ-028 SHALL, with UART_RX_PARITY_EN, on a parity mismatch still sample the stop bit, then pulse PARITY_ERR (or FRAME_ERR if stop=0) instead of VALID, leaving DATA_OUT unchanged.
REQ-029 SHALL, without UART_RX_PARITY_EN, omit the PARITY_BIT state, tie PARITY_ERR to 0, and use a 10-bit frame.

Verification
REQ-030 SHALL cover: after RST, drive frame 0xA5 MSB first at 434 cycles/bit -> exactly one VALID pulse, DATA_OUT=0xA5, BUSY falls the next cycle.
REQ-031 SHALL cover: RX_IN low for 100 cycles, then high -> false start, BUSY pulses then clears, no VALID and no FRAME_ERR.
REQ-032 SHALL cover: frame 0x3C with stop bit 0 -> one FRAME_ERR pulse, DATA_OUT keeps the previous value 0xA5, VALID stays 0.
REQ-033 SHALL cover: frames 0x00 then 0xFF back-to-back, no idle gap -> two VALID pulses 4340 cycles apart, values 0x00 then 0xFF.
REQ-034 SHALL cover: RST asserted for 1 cycle during data bit 4 of 0x81 -> no pulse, next frame 0x42 gives DATA_OUT=0x42.
REQ-035 SHALL cover, with UART_RX_PARITY_EN: 0x07 sent with parity bit 0 -> PARITY_ERR pulse, no VALID; 0x07 with parity bit 1 -> VALID, DATA_OUT=0x07.
